// File: rtl/dataflow_pkg.sv
// Pipeline stage identifiers shared across the core.
package dataflow_pkg;

    typedef enum logic [1:0] {
        Decode    = 2'd0,
        Execute   = 2'd1,
        Memory    = 2'd2,
        WriteBack = 2'd3
    } stages_t;

endpackage

// File: rtl/forwarding_unit_pkg.sv
// Forwarding encodings and the stage-pair permission rule.
package forwarding_unit_pkg;
    import dataflow_pkg::*;

    localparam int unsigned FWD_W   = 2;
    localparam int unsigned COUNT_W = 32;

    typedef enum logic [1:0] {
        NoForward            = 2'd0,
        ForwardExecute       = 2'd1,
        ForwardDecode        = 2'd2,
        ForwardExecuteMemory = 2'd3
    } forwarding_type_t;

    typedef enum logic [1:0] {
        NoForwarding   = 2'd0,
        ForwardFromEx  = 2'd1,
        ForwardFromMem = 2'd2,
        ForwardFromWb  = 2'd3
    } forwarding_t;

    // Whether a consumer of the given type in stage cons may take a result from stage src.
    function automatic logic fwd_allowed(forwarding_type_t t, stages_t cons,
                                         stages_t src, logic is_rs2);
        logic exec_ok;
        exec_ok = ((cons == Decode)  && (src == WriteBack)) ||
                  ((cons == Execute) && ((src == Memory) || (src == WriteBack)));
        case (t)
            ForwardExecute:       fwd_allowed = exec_ok;
            ForwardDecode:        fwd_allowed = (cons == Decode) && (src != Decode);
            ForwardExecuteMemory: fwd_allowed = exec_ok ||
                                                ((cons == Memory) && (src == WriteBack) && is_rs2);
            default:              fwd_allowed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/forwarding_select.sv
// Single-operand bypass selector: youngest matching and permitted stage wins.
module forwarding_select
    import dataflow_pkg::*;
    import forwarding_unit_pkg::*;
#(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0]     rs_i,
    input  logic             is_rs2_i,
    input  forwarding_type_t type_i,
    input  stages_t          stage_i,
    input  logic [N-1:0]     rd_ex_i,
    input  logic             we_ex_i,
    input  logic [N-1:0]     rd_mem_i,
    input  logic             we_mem_i,
    input  logic [N-1:0]     rd_wb_i,
    input  logic             we_wb_i,
    output forwarding_t      forward_o
);

    logic hit_ex_c;
    logic hit_mem_c;
    logic hit_wb_c;

    // A source qualifies when its destination matches, is not x0, is written, and is permitted.
    always_comb begin
        hit_ex_c  = (rs_i == rd_ex_i)  && (rd_ex_i  != '0) && we_ex_i &&
                    fwd_allowed(type_i, stage_i, Execute, is_rs2_i);
        hit_mem_c = (rs_i == rd_mem_i) && (rd_mem_i != '0) && we_mem_i &&
                    fwd_allowed(type_i, stage_i, Memory, is_rs2_i);
        hit_wb_c  = (rs_i == rd_wb_i)  && (rd_wb_i  != '0) && we_wb_i &&
                    fwd_allowed(type_i, stage_i, WriteBack, is_rs2_i);
    end

    // Priority chain EX > MEM > WB > register file.
    always_comb begin
        forward_o = NoForwarding;
        if (hit_ex_c) begin
            forward_o = ForwardFromEx;
        end else if (hit_mem_c) begin
            forward_o = ForwardFromMem;
        end else if (hit_wb_c) begin
            forward_o = ForwardFromWb;
        end
    end

endmodule

// File: rtl/forwarding_unit.sv
// Hazard-forwarding selector for the ID/EX/MEM consumers of the pipeline.
// Optional FORWARDING_COUNTERS_EN adds forward_count, counting cycles with any active bypass.
module forwarding_unit
    import dataflow_pkg::*;
    import forwarding_unit_pkg::*;
#(
    parameter int unsigned N = 5
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [1:0]   forwarding_type_id,
    input  logic [1:0]   forwarding_type_ex,
    input  logic [1:0]   forwarding_type_mem,
    input  logic         reg_we_ex,
    input  logic         reg_we_mem,
    input  logic         reg_we_wb,
    input  logic [N-1:0] rd_ex,
    input  logic [N-1:0] rd_mem,
    input  logic [N-1:0] rd_wb,
    input  logic [N-1:0] rs1_id,
    input  logic [N-1:0] rs2_id,
    input  logic [N-1:0] rs1_ex,
    input  logic [N-1:0] rs2_ex,
    input  logic [N-1:0] rs2_mem,
    output logic [1:0]   forward_rs1_id,
    output logic [1:0]   forward_rs2_id,
    output logic [1:0]   forward_rs1_ex,
    output logic [1:0]   forward_rs2_ex,
    output logic [1:0]   forward_rs2_mem
`ifdef FORWARDING_COUNTERS_EN
    ,
    output logic [31:0]  forward_count
`endif
);

    forwarding_type_t type_id_c;
    forwarding_type_t type_ex_c;
    forwarding_type_t type_mem_c;
    forwarding_t      fwd_rs1_id_c;
    forwarding_t      fwd_rs2_id_c;
    forwarding_t      fwd_rs1_ex_c;
    forwarding_t      fwd_rs2_ex_c;
    forwarding_t      fwd_rs2_mem_c;

    assign type_id_c  = forwarding_type_t'(forwarding_type_id);
    assign type_ex_c  = forwarding_type_t'(forwarding_type_ex);
    assign type_mem_c = forwarding_type_t'(forwarding_type_mem);

    // Decode consumers see all three older stages.
    forwarding_select #(.N(N)) u_rs1_id (
        .rs_i(rs1_id), .is_rs2_i(1'b0), .type_i(type_id_c), .stage_i(Decode),
        .rd_ex_i(rd_ex), .we_ex_i(reg_we_ex), .rd_mem_i(rd_mem), .we_mem_i(reg_we_mem),
        .rd_wb_i(rd_wb), .we_wb_i(reg_we_wb), .forward_o(fwd_rs1_id_c)
    );

    forwarding_select #(.N(N)) u_rs2_id (
        .rs_i(rs2_id), .is_rs2_i(1'b1), .type_i(type_id_c), .stage_i(Decode),
        .rd_ex_i(rd_ex), .we_ex_i(reg_we_ex), .rd_mem_i(rd_mem), .we_mem_i(reg_we_mem),
        .rd_wb_i(rd_wb), .we_wb_i(reg_we_wb), .forward_o(fwd_rs2_id_c)
    );

    // Execute consumers cannot bypass from themselves.
    forwarding_select #(.N(N)) u_rs1_ex (
        .rs_i(rs1_ex), .is_rs2_i(1'b0), .type_i(type_ex_c), .stage_i(Execute),
        .rd_ex_i(rd_ex), .we_ex_i(1'b0), .rd_mem_i(rd_mem), .we_mem_i(reg_we_mem),
        .rd_wb_i(rd_wb), .we_wb_i(reg_we_wb), .forward_o(fwd_rs1_ex_c)
    );

    forwarding_select #(.N(N)) u_rs2_ex (
        .rs_i(rs2_ex), .is_rs2_i(1'b1), .type_i(type_ex_c), .stage_i(Execute),
        .rd_ex_i(rd_ex), .we_ex_i(1'b0), .rd_mem_i(rd_mem), .we_mem_i(reg_we_mem),
        .rd_wb_i(rd_wb), .we_wb_i(reg_we_wb), .forward_o(fwd_rs2_ex_c)
    );

    // Memory-stage store data may only come from writeback.
    forwarding_select #(.N(N)) u_rs2_mem (
        .rs_i(rs2_mem), .is_rs2_i(1'b1), .type_i(type_mem_c), .stage_i(Memory),
        .rd_ex_i(rd_ex), .we_ex_i(1'b0), .rd_mem_i(rd_mem), .we_mem_i(1'b0),
        .rd_wb_i(rd_wb), .we_wb_i(reg_we_wb), .forward_o(fwd_rs2_mem_c)
    );

    assign forward_rs1_id  = FWD_W'(fwd_rs1_id_c);
    assign forward_rs2_id  = FWD_W'(fwd_rs2_id_c);
    assign forward_rs1_ex  = FWD_W'(fwd_rs1_ex_c);
    assign forward_rs2_ex  = FWD_W'(fwd_rs2_ex_c);
    assign forward_rs2_mem = FWD_W'(fwd_rs2_mem_c);

`ifdef FORWARDING_COUNTERS_EN
    logic               any_fwd_c;
    logic [COUNT_W-1:0] count_d;
    logic [COUNT_W-1:0] count_q;

    // Next count: bump on any active bypass, wrapping naturally.
    always_comb begin
        any_fwd_c = (fwd_rs1_id_c  != NoForwarding) || (fwd_rs2_id_c != NoForwarding) ||
                    (fwd_rs1_ex_c  != NoForwarding) || (fwd_rs2_ex_c != NoForwarding) ||
                    (fwd_rs2_mem_c != NoForwarding);
        count_d   = count_q + COUNT_W'(any_fwd_c);
    end

    // Statistics register, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign forward_count = count_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clock, reset_n};
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// Scoreboard bench for forwarding_unit; counter checks when FORWARDING_COUNTERS_EN is defined.
module tb_forwarding_unit;

    localparam int unsigned N = 5;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [1:0]   type_id, type_ex, type_mem;
    logic         we_ex, we_mem, we_wb;
    logic [N-1:0] rd_ex, rd_mem, rd_wb;
    logic [N-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rs2_mem;
    logic [1:0]   f_rs1_id, f_rs2_id, f_rs1_ex, f_rs2_ex, f_rs2_mem;
`ifdef FORWARDING_COUNTERS_EN
    logic [31:0]  fcount;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    always #5 clock = ~clock;

    forwarding_unit #(.N(N)) dut (
        .clock(clock), .reset_n(reset_n),
        .forwarding_type_id(type_id), .forwarding_type_ex(type_ex),
        .forwarding_type_mem(type_mem),
        .reg_we_ex(we_ex), .reg_we_mem(we_mem), .reg_we_wb(we_wb),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rs2_mem(rs2_mem),
        .forward_rs1_id(f_rs1_id), .forward_rs2_id(f_rs2_id),
        .forward_rs1_ex(f_rs1_ex), .forward_rs2_ex(f_rs2_ex),
        .forward_rs2_mem(f_rs2_mem)
`ifdef FORWARDING_COUNTERS_EN
        , .forward_count(fcount)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: cons 0=ID, 1=EX, 2=MEM. Caller masks disabled sources' write enables.
    function automatic logic [1:0] model(int cons, bit is_rs2, logic [1:0] t, logic [N-1:0] rs,
                                         logic [N-1:0] re, logic ee, logic [N-1:0] rm,
                                         logic em, logic [N-1:0] rw, logic ew);
        bit ok_ex = 0, ok_mem = 0, ok_wb = 0;
        case (t)
            2'd1: begin ok_mem = (cons == 1); ok_wb = (cons <= 1); end
            2'd2: begin ok_ex = (cons == 0); ok_mem = (cons == 0); ok_wb = (cons == 0); end
            2'd3: begin ok_mem = (cons == 1); ok_wb = (cons <= 1) || (cons == 2 && is_rs2); end
            default: ;
        endcase
        if (ok_ex  && ee && re != 0 && rs == re) return 2'd1;
        if (ok_mem && em && rm != 0 && rs == rm) return 2'd2;
        if (ok_wb  && ew && rw != 0 && rs == rw) return 2'd3;
        return 2'd0;
    endfunction

    task automatic clear_inputs();
        {type_id, type_ex, type_mem} = '0;
        {we_ex, we_mem, we_wb} = '0;
        {rd_ex, rd_mem, rd_wb} = '0;
        {rs1_id, rs2_id, rs1_ex, rs2_ex, rs2_mem} = '0;
    endtask

    task automatic push_all();
        exp_q.push_back(model(0, 0, type_id,  rs1_id,  rd_ex, we_ex, rd_mem, we_mem, rd_wb, we_wb));
        exp_q.push_back(model(0, 1, type_id,  rs2_id,  rd_ex, we_ex, rd_mem, we_mem, rd_wb, we_wb));
        exp_q.push_back(model(1, 0, type_ex,  rs1_ex,  rd_ex, 1'b0,  rd_mem, we_mem, rd_wb, we_wb));
        exp_q.push_back(model(1, 1, type_ex,  rs2_ex,  rd_ex, 1'b0,  rd_mem, we_mem, rd_wb, we_wb));
        exp_q.push_back(model(2, 1, type_mem, rs2_mem, rd_ex, 1'b0,  rd_mem, 1'b0,  rd_wb, we_wb));
    endtask

    task automatic pop_all(input string tag);
        if (exp_q.size() < 5) begin
            check_eq({tag, "_queue"}, 32'(exp_q.size()), 32'd5);
            exp_q.delete();
            return;
        end
        check_eq({tag, "_rs1_id"},  32'(f_rs1_id),  32'(exp_q.pop_front()));
        check_eq({tag, "_rs2_id"},  32'(f_rs2_id),  32'(exp_q.pop_front()));
        check_eq({tag, "_rs1_ex"},  32'(f_rs1_ex),  32'(exp_q.pop_front()));
        check_eq({tag, "_rs2_ex"},  32'(f_rs2_ex),  32'(exp_q.pop_front()));
        check_eq({tag, "_rs2_mem"}, 32'(f_rs2_mem), 32'(exp_q.pop_front()));
    endtask

    // Push a hand-derived constant, settle, then compare against the named output.
    task automatic directed(input string tag, input int which, input logic [1:0] exp);
        logic [1:0] obs;
        exp_q.push_back(exp);
        #1;
        case (which)
            0: obs = f_rs1_id;
            1: obs = f_rs2_id;
            2: obs = f_rs1_ex;
            3: obs = f_rs2_ex;
            default: obs = f_rs2_mem;
        endcase
        check_eq(tag, 32'(obs), 32'(exp_q.pop_front()));
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        #1;
        check_eq("reset_rs1_id", 32'(f_rs1_id), 32'd0);
        check_eq("reset_rs2_mem", 32'(f_rs2_mem), 32'd0);
`ifdef FORWARDING_COUNTERS_EN
        check_eq("reset_count", fcount, 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;

`ifdef FORWARDING_COUNTERS_EN
        // Ten cycles with a single active bypass.
        @(negedge clock);
        type_id = 2'd2; rs1_id = 5'd4; rd_ex = 5'd4; we_ex = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        clear_inputs();
        #1;
        check_eq("count_ten", fcount, 32'd10);
        @(posedge clock);
        #2;
        check_eq("count_hold", fcount, 32'd10);
        reset_n = 1'b0;
        #1;
        check_eq("count_async_clr", fcount, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
`endif

        @(negedge clock);
        clear_inputs();
        type_id = 2'd2; rs1_id = 5'd3; rd_ex = 5'd3; rd_mem = 5'd3;
        {we_ex, we_mem, we_wb} = 3'b111;
        directed("decode_ex_first", 0, 2'd1);

        @(negedge clock);
        clear_inputs();
        type_id = 2'd1; rs1_id = 5'd3; rd_ex = 5'd3; rd_mem = 5'd3; rd_wb = 5'd3;
        {we_ex, we_mem, we_wb} = 3'b111;
        directed("id_exec_type_wb", 0, 2'd3);

        @(negedge clock);
        clear_inputs();
        type_ex = 2'd1; rs2_ex = 5'd7; rd_ex = 5'd7; we_ex = 1'b1;
        rd_mem = 5'd7; we_mem = 1'b0; rd_wb = 5'd7; we_wb = 1'b1;
        directed("ex_mem_we0_wb", 3, 2'd3);

        @(negedge clock);
        clear_inputs();
        type_ex = 2'd1; rs1_ex = 5'd6; rd_mem = 5'd6; we_mem = 1'b1; rd_wb = 5'd6; we_wb = 1'b1;
        directed("ex_mem_over_wb", 2, 2'd2);

        @(negedge clock);
        clear_inputs();
        type_mem = 2'd3; rs2_mem = 5'd9; rd_wb = 5'd9; we_wb = 1'b1;
        directed("mem_exec_mem_wb", 4, 2'd3);
        type_mem = 2'd1;
        directed("mem_exec_none", 4, 2'd0);

        @(negedge clock);
        clear_inputs();
        for (int t = 0; t < 4; t++) begin
            type_id = 2'(t); rs1_id = '0; rd_ex = '0; rd_mem = '0; rd_wb = '0;
            {we_ex, we_mem, we_wb} = 3'b111;
            directed($sformatf("x0_type%0d", t), 0, 2'd0);
        end

        clear_inputs();
        type_id = 2'd0; rs2_id = 5'd12; rd_ex = 5'd12; rd_mem = 5'd12; rd_wb = 5'd12;
        {we_ex, we_mem, we_wb} = 3'b111;
        directed("noforward_full_match", 1, 2'd0);

        // Random vectors with a small register range so matches are frequent.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clock);
            type_id = 2'($urandom_range(3)); type_ex = 2'($urandom_range(3));
            type_mem = 2'($urandom_range(3));
            we_ex = 1'($urandom); we_mem = 1'($urandom); we_wb = 1'($urandom);
            rd_ex = N'($urandom_range(3)); rd_mem = N'($urandom_range(3));
            rd_wb = N'($urandom_range(3));
            rs1_id = N'($urandom_range(3)); rs2_id = N'($urandom_range(3));
            rs1_ex = N'($urandom_range(3)); rs2_ex = N'($urandom_range(3));
            rs2_mem = N'($urandom_range(3));
            if (i % 50 == 0) begin
                rd_ex = N'($urandom); rs1_id = rd_ex;
            end
            push_all();
            #1;
            pop_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
